// File: rtl/gpio_bus_arb_if.sv
// Request-side and ic0-side signal bundle for gpio_bus_arb.
// master = the arbiter (it masters ic0), slave = the clients and GPIO slaves around it.
interface gpio_bus_arb_if;
  logic        rq0_valid;
  logic        rq0_we;
  logic [31:0] rq0_addr;
  logic [31:0] rq0_wdata;
  logic        rq0_ready;
  logic        rq0_rsp_valid;
  logic [31:0] rq0_rsp_data;
  logic        rq0_rsp_err;

  logic        rq1_valid;
  logic        rq1_we;
  logic [31:0] rq1_addr;
  logic [31:0] rq1_wdata;
  logic        rq1_ready;
  logic        rq1_rsp_valid;
  logic [31:0] rq1_rsp_data;
  logic        rq1_rsp_err;

  logic        ic0_c_axi_mst_wr_valid;
  logic        ic0_c_axi_mst_rd_valid;
  logic [31:0] ic0_axi_mst_wr_addr;
  logic [31:0] ic0_axi_mst_wr_data;
  logic [31:0] ic0_axi_mst_rd_addr;
  logic        ic0_c_axi_slv_rd_ready_0;
  logic [31:0] ic0_axi_slv_rd_data_0;

  modport master (
    input  rq0_valid, rq0_we, rq0_addr, rq0_wdata,
    output rq0_ready, rq0_rsp_valid, rq0_rsp_data, rq0_rsp_err,
    input  rq1_valid, rq1_we, rq1_addr, rq1_wdata,
    output rq1_ready, rq1_rsp_valid, rq1_rsp_data, rq1_rsp_err,
    output ic0_c_axi_mst_wr_valid, ic0_c_axi_mst_rd_valid,
    output ic0_axi_mst_wr_addr, ic0_axi_mst_wr_data, ic0_axi_mst_rd_addr,
    input  ic0_c_axi_slv_rd_ready_0, ic0_axi_slv_rd_data_0
  );

  modport slave (
    output rq0_valid, rq0_we, rq0_addr, rq0_wdata,
    input  rq0_ready, rq0_rsp_valid, rq0_rsp_data, rq0_rsp_err,
    output rq1_valid, rq1_we, rq1_addr, rq1_wdata,
    input  rq1_ready, rq1_rsp_valid, rq1_rsp_data, rq1_rsp_err,
    input  ic0_c_axi_mst_wr_valid, ic0_c_axi_mst_rd_valid,
    input  ic0_axi_mst_wr_addr, ic0_axi_mst_wr_data, ic0_axi_mst_rd_addr,
    output ic0_c_axi_slv_rd_ready_0, ic0_axi_slv_rd_data_0
  );
endinterface

// File: rtl/gpio_bus_arb.sv
// Round-robin two-client arbiter/sequencer for the ic0 GPIO register bus, one read in flight.
// Define GPIO_BUS_ARB_TIMEOUT_EN to compile in the read timeout counter and error response.
//
// state   | meaning
// IDLE    | accepting requests; writes complete here back-to-back
// RD_WAIT | read strobed, waiting for ic0 read-ready (or timeout)
module gpio_bus_arb #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input logic            clk,
  input logic            rst_n,
  gpio_bus_arb_if.master bus
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  logic        last;
  logic        owner;

  logic        wr_valid_q;
  logic        rd_valid_q;
  logic [31:0] wr_addr_q;
  logic [31:0] wr_data_q;
  logic [31:0] rd_addr_q;
  logic [1:0]  rsp_valid_q;
  logic [31:0] rsp_data0_q;
  logic [31:0] rsp_data1_q;

  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        sel;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  // On contention the grant goes to whoever was not served last.
  always_comb begin
    grant0    = (state == IDLE) && bus.rq0_valid && (!bus.rq1_valid || last);
    grant1    = (state == IDLE) && bus.rq1_valid && (!bus.rq0_valid || !last);
    accept    = grant0 || grant1;
    sel       = grant1;
    req_we    = sel ? bus.rq1_we    : bus.rq0_we;
    req_addr  = sel ? bus.rq1_addr  : bus.rq0_addr;
    req_wdata = sel ? bus.rq1_wdata : bus.rq0_wdata;
  end

`ifdef GPIO_BUS_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic [1:0] rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= 1'b1;
      owner       <= 1'b0;
      tmo_cnt     <= 8'd0;
      wr_valid_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_addr_q   <= 32'd0;
      wr_data_q   <= 32'd0;
      rd_addr_q   <= 32'd0;
      rsp_valid_q <= 2'b00;
      rsp_data0_q <= 32'd0;
      rsp_data1_q <= 32'd0;
      rsp_err_q   <= 2'b00;
    end else begin
      wr_valid_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_addr_q   <= 32'd0;
      wr_data_q   <= 32'd0;
      rd_addr_q   <= 32'd0;
      rsp_valid_q <= 2'b00;
      rsp_data0_q <= 32'd0;
      rsp_data1_q <= 32'd0;
      rsp_err_q   <= 2'b00;
      case (state)
        IDLE: begin
          if (accept) begin
            last <= sel;
            if (req_we) begin
              wr_valid_q       <= 1'b1;
              wr_addr_q        <= req_addr;
              wr_data_q        <= req_wdata;
              rsp_valid_q[sel] <= 1'b1;
            end else begin
              rd_valid_q <= 1'b1;
              rd_addr_q  <= req_addr;
              owner      <= sel;
              tmo_cnt    <= 8'd0;
              state      <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // A read-ready arriving on the timeout cycle still delivers real data.
          if (bus.ic0_c_axi_slv_rd_ready_0) begin
            rsp_valid_q[owner] <= 1'b1;
            if (owner) rsp_data1_q <= bus.ic0_axi_slv_rd_data_0;
            else       rsp_data0_q <= bus.ic0_axi_slv_rd_data_0;
            state <= IDLE;
          end else if (tmo_cnt == TIMEOUT_CNT) begin
            rsp_valid_q[owner] <= 1'b1;
            rsp_err_q[owner]   <= 1'b1;
            if (owner) rsp_data1_q <= ERR_DATA;
            else       rsp_data0_q <= ERR_DATA;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rq0_rsp_err = rsp_err_q[0];
  assign bus.rq1_rsp_err = rsp_err_q[1];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= 1'b1;
      owner       <= 1'b0;
      wr_valid_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_addr_q   <= 32'd0;
      wr_data_q   <= 32'd0;
      rd_addr_q   <= 32'd0;
      rsp_valid_q <= 2'b00;
      rsp_data0_q <= 32'd0;
      rsp_data1_q <= 32'd0;
    end else begin
      wr_valid_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_addr_q   <= 32'd0;
      wr_data_q   <= 32'd0;
      rd_addr_q   <= 32'd0;
      rsp_valid_q <= 2'b00;
      rsp_data0_q <= 32'd0;
      rsp_data1_q <= 32'd0;
      case (state)
        IDLE: begin
          if (accept) begin
            last <= sel;
            if (req_we) begin
              wr_valid_q       <= 1'b1;
              wr_addr_q        <= req_addr;
              wr_data_q        <= req_wdata;
              rsp_valid_q[sel] <= 1'b1;
            end else begin
              rd_valid_q <= 1'b1;
              rd_addr_q  <= req_addr;
              owner      <= sel;
              state      <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // Without the timeout path a missing slave holds the bus until read-ready.
          if (bus.ic0_c_axi_slv_rd_ready_0) begin
            rsp_valid_q[owner] <= 1'b1;
            if (owner) rsp_data1_q <= bus.ic0_axi_slv_rd_data_0;
            else       rsp_data0_q <= bus.ic0_axi_slv_rd_data_0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_cfg;
  assign unused_cfg      = ^{ERR_DATA, TIMEOUT_CNT};
  assign bus.rq0_rsp_err = 1'b0;
  assign bus.rq1_rsp_err = 1'b0;
`endif

  assign bus.rq0_ready              = grant0;
  assign bus.rq1_ready              = grant1;
  assign bus.rq0_rsp_valid          = rsp_valid_q[0];
  assign bus.rq1_rsp_valid          = rsp_valid_q[1];
  assign bus.rq0_rsp_data           = rsp_data0_q;
  assign bus.rq1_rsp_data           = rsp_data1_q;
  assign bus.ic0_c_axi_mst_wr_valid = wr_valid_q;
  assign bus.ic0_c_axi_mst_rd_valid = rd_valid_q;
  assign bus.ic0_axi_mst_wr_addr    = wr_addr_q;
  assign bus.ic0_axi_mst_wr_data    = wr_data_q;
  assign bus.ic0_axi_mst_rd_addr    = rd_addr_q;

endmodule

// File: tb/tb_gpio_bus_arb.sv
// Directed self-checking bench for gpio_bus_arb (TIMEOUT=4).
module tb_gpio_bus_arb;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  gpio_bus_arb_if bus ();

  gpio_bus_arb #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, " wr_valid"}, {31'd0, bus.ic0_c_axi_mst_wr_valid}, 32'd0);
    chk({tag, " rd_valid"}, {31'd0, bus.ic0_c_axi_mst_rd_valid}, 32'd0);
    chk({tag, " wr_addr"},  bus.ic0_axi_mst_wr_addr, 32'd0);
    chk({tag, " rd_addr"},  bus.ic0_axi_mst_rd_addr, 32'd0);
    chk({tag, " rsp0"},     {31'd0, bus.rq0_rsp_valid}, 32'd0);
    chk({tag, " rsp1"},     {31'd0, bus.rq1_rsp_valid}, 32'd0);
    chk({tag, " rsp0_data"}, bus.rq0_rsp_data, 32'd0);
    chk({tag, " rsp1_data"}, bus.rq1_rsp_data, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.rq0_valid = 1'b0; bus.rq0_we = 1'b0; bus.rq0_addr = 32'd0; bus.rq0_wdata = 32'd0;
    bus.rq1_valid = 1'b0; bus.rq1_we = 1'b0; bus.rq1_addr = 32'd0; bus.rq1_wdata = 32'd0;
    bus.ic0_c_axi_slv_rd_ready_0 = 1'b0;
    bus.ic0_axi_slv_rd_data_0 = 32'd0;
    cyc(); cyc();
    idle_outputs("reset");
    rst_n = 1'b1;
    cyc();

    // single write from rq0
    bus.rq0_valid = 1'b1; bus.rq0_we = 1'b1; bus.rq0_addr = 32'h454; bus.rq0_wdata = 32'hF;
    #1;
    chk("w1 ready0", {31'd0, bus.rq0_ready}, 32'd1);
    cyc();
    bus.rq0_valid = 1'b0;
    #1;
    chk("w1 wr_valid", {31'd0, bus.ic0_c_axi_mst_wr_valid}, 32'd1);
    chk("w1 wr_addr", bus.ic0_axi_mst_wr_addr, 32'h454);
    chk("w1 wr_data", bus.ic0_axi_mst_wr_data, 32'hF);
    chk("w1 rsp0", {31'd0, bus.rq0_rsp_valid}, 32'd1);
    chk("w1 rsp0_err", {31'd0, bus.rq0_rsp_err}, 32'd0);
    chk("w1 rsp0_data", bus.rq0_rsp_data, 32'd0);
    cyc();
    idle_outputs("w1 after");

    // rq1 read, slave answers at T+2
    bus.rq1_valid = 1'b1; bus.rq1_we = 1'b0; bus.rq1_addr = 32'h460;
    #1;
    chk("r1 ready1", {31'd0, bus.rq1_ready}, 32'd1);
    chk("r1 ready0", {31'd0, bus.rq0_ready}, 32'd0);
    cyc();
    bus.rq1_valid = 1'b0;
    #1;
    chk("r1 rd_valid", {31'd0, bus.ic0_c_axi_mst_rd_valid}, 32'd1);
    chk("r1 rd_addr", bus.ic0_axi_mst_rd_addr, 32'h460);
    chk("r1 wr_valid", {31'd0, bus.ic0_c_axi_mst_wr_valid}, 32'd0);
    cyc();
    bus.ic0_c_axi_slv_rd_ready_0 = 1'b1; bus.ic0_axi_slv_rd_data_0 = 32'h5;
    #1;
    chk("r1 rd_valid T2", {31'd0, bus.ic0_c_axi_mst_rd_valid}, 32'd0);
    chk("r1 rsp1 T2", {31'd0, bus.rq1_rsp_valid}, 32'd0);
    cyc();
    bus.ic0_c_axi_slv_rd_ready_0 = 1'b0; bus.ic0_axi_slv_rd_data_0 = 32'd0;
    #1;
    chk("r1 rsp1", {31'd0, bus.rq1_rsp_valid}, 32'd1);
    chk("r1 rsp1_data", bus.rq1_rsp_data, 32'h5);
    chk("r1 rsp1_err", {31'd0, bus.rq1_rsp_err}, 32'd0);
    chk("r1 rsp0", {31'd0, bus.rq0_rsp_valid}, 32'd0);
    chk("r1 rsp0_data", bus.rq0_rsp_data, 32'd0);
    cyc();
    chk("r1 rsp1 after", {31'd0, bus.rq1_rsp_valid}, 32'd0);

    // both clients hold writes: grants alternate, last was rq1 so rq0 first
    bus.rq0_valid = 1'b1; bus.rq0_we = 1'b1; bus.rq0_addr = 32'h100; bus.rq0_wdata = 32'hA0;
    bus.rq1_valid = 1'b1; bus.rq1_we = 1'b1; bus.rq1_addr = 32'h200; bus.rq1_wdata = 32'hB0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr ready0", {31'd0, bus.rq0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr ready1", {31'd0, bus.rq1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr wr_valid", {31'd0, bus.ic0_c_axi_mst_wr_valid}, (i > 0) ? 32'd1 : 32'd0);
      if (i > 0)
        chk("rr wr_addr", bus.ic0_axi_mst_wr_addr, (i % 2 == 1) ? 32'h100 : 32'h200);
      cyc();
    end
    bus.rq0_valid = 1'b0; bus.rq1_valid = 1'b0;
    #1;
    chk("rr last wr_valid", {31'd0, bus.ic0_c_axi_mst_wr_valid}, 32'd1);
    chk("rr last wr_addr", bus.ic0_axi_mst_wr_addr, 32'h200);
    chk("rr last wr_data", bus.ic0_axi_mst_wr_data, 32'hB0);
    chk("rr last rsp1", {31'd0, bus.rq1_rsp_valid}, 32'd1);
    chk("rr last rsp0", {31'd0, bus.rq0_rsp_valid}, 32'd0);
    cyc();

    // rq0 read outstanding blocks rq1 until the response cycle
    bus.rq0_valid = 1'b1; bus.rq0_we = 1'b0; bus.rq0_addr = 32'h300;
    bus.rq1_valid = 1'b1; bus.rq1_we = 1'b1; bus.rq1_addr = 32'h304; bus.rq1_wdata = 32'h77;
    #1;
    chk("blk ready0", {31'd0, bus.rq0_ready}, 32'd1);
    chk("blk ready1 T0", {31'd0, bus.rq1_ready}, 32'd0);
    cyc();
    bus.rq0_valid = 1'b0;
    #1;
    chk("blk rd_addr", bus.ic0_axi_mst_rd_addr, 32'h300);
    chk("blk ready1 T1", {31'd0, bus.rq1_ready}, 32'd0);
    cyc();
    bus.ic0_c_axi_slv_rd_ready_0 = 1'b1; bus.ic0_axi_slv_rd_data_0 = 32'h1234;
    #1;
    chk("blk ready1 T2", {31'd0, bus.rq1_ready}, 32'd0);
    cyc();
    bus.ic0_c_axi_slv_rd_ready_0 = 1'b0; bus.ic0_axi_slv_rd_data_0 = 32'd0;
    #1;
    chk("blk rsp0", {31'd0, bus.rq0_rsp_valid}, 32'd1);
    chk("blk rsp0_data", bus.rq0_rsp_data, 32'h1234);
    chk("blk ready1 T3", {31'd0, bus.rq1_ready}, 32'd1);
    cyc();
    bus.rq1_valid = 1'b0;
    #1;
    chk("blk wr_valid", {31'd0, bus.ic0_c_axi_mst_wr_valid}, 32'd1);
    chk("blk wr_addr", bus.ic0_axi_mst_wr_addr, 32'h304);
    chk("blk wr_data", bus.ic0_axi_mst_wr_data, 32'h77);
    chk("blk rsp1", {31'd0, bus.rq1_rsp_valid}, 32'd1);
    cyc();

    // read-ready while idle is ignored
    bus.ic0_c_axi_slv_rd_ready_0 = 1'b1; bus.ic0_axi_slv_rd_data_0 = 32'h55;
    cyc();
    bus.ic0_c_axi_slv_rd_ready_0 = 1'b0; bus.ic0_axi_slv_rd_data_0 = 32'd0;
    idle_outputs("idle rdy");
    cyc();

`ifdef GPIO_BUS_ARB_TIMEOUT_EN
    // read to nowhere: error response at T+6
    bus.rq0_valid = 1'b1; bus.rq0_we = 1'b0; bus.rq0_addr = 32'hFFC;
    #1;
    chk("tmo ready0", {31'd0, bus.rq0_ready}, 32'd1);
    cyc();
    bus.rq0_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk("tmo no rsp", {31'd0, bus.rq0_rsp_valid}, 32'd0);
      cyc();
    end
    bus.rq1_valid = 1'b1; bus.rq1_we = 1'b1; bus.rq1_addr = 32'h500; bus.rq1_wdata = 32'h9;
    #1;
    chk("tmo rsp0", {31'd0, bus.rq0_rsp_valid}, 32'd1);
    chk("tmo rsp0_err", {31'd0, bus.rq0_rsp_err}, 32'd1);
    chk("tmo rsp0_data", bus.rq0_rsp_data, 32'hDEADBEEF);
    chk("tmo idle ready1", {31'd0, bus.rq1_ready}, 32'd1);
    cyc();
    bus.rq1_valid = 1'b0;
    #1;
    chk("tmo wr_addr", bus.ic0_axi_mst_wr_addr, 32'h500);
    chk("tmo err clear", {31'd0, bus.rq0_rsp_err}, 32'd0);
    cyc();
`else
    // no timeout: read holds until read-ready, however late
    bus.rq0_valid = 1'b1; bus.rq0_we = 1'b0; bus.rq0_addr = 32'hFFC;
    #1;
    chk("hold ready0", {31'd0, bus.rq0_ready}, 32'd1);
    cyc();
    bus.rq0_valid = 1'b0;
    bus.rq1_valid = 1'b1; bus.rq1_we = 1'b1; bus.rq1_addr = 32'h500; bus.rq1_wdata = 32'h9;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk("hold no rsp", {31'd0, bus.rq0_rsp_valid}, 32'd0);
      chk("hold ready1", {31'd0, bus.rq1_ready}, 32'd0);
      cyc();
    end
    bus.ic0_c_axi_slv_rd_ready_0 = 1'b1; bus.ic0_axi_slv_rd_data_0 = 32'hCAFE;
    cyc();
    bus.ic0_c_axi_slv_rd_ready_0 = 1'b0; bus.ic0_axi_slv_rd_data_0 = 32'd0;
    #1;
    chk("hold rsp0", {31'd0, bus.rq0_rsp_valid}, 32'd1);
    chk("hold rsp0_data", bus.rq0_rsp_data, 32'hCAFE);
    chk("hold rsp0_err", {31'd0, bus.rq0_rsp_err}, 32'd0);
    chk("hold ready1 free", {31'd0, bus.rq1_ready}, 32'd1);
    cyc();
    bus.rq1_valid = 1'b0;
    #1;
    chk("hold wr_addr", bus.ic0_axi_mst_wr_addr, 32'h500);
    cyc();
`endif

    // reset in the middle of a read drops it
    bus.rq1_valid = 1'b1; bus.rq1_we = 1'b0; bus.rq1_addr = 32'h400;
    #1;
    chk("rst ready1", {31'd0, bus.rq1_ready}, 32'd1);
    cyc();
    bus.rq1_valid = 1'b0;
    #1;
    chk("rst rd_valid", {31'd0, bus.ic0_c_axi_mst_rd_valid}, 32'd1);
    cyc();
    bus.ic0_c_axi_slv_rd_ready_0 = 1'b1; bus.ic0_axi_slv_rd_data_0 = 32'h66;
    rst_n = 1'b0;
    #1;
    idle_outputs("rst mid");
    cyc();
    bus.ic0_c_axi_slv_rd_ready_0 = 1'b0; bus.ic0_axi_slv_rd_data_0 = 32'd0;
    rst_n = 1'b1;
    cyc();
    idle_outputs("rst after1");
    cyc();
    idle_outputs("rst after2");
    bus.rq0_valid = 1'b1; bus.rq0_we = 1'b1; bus.rq0_addr = 32'h600; bus.rq0_wdata = 32'h1;
    bus.rq1_valid = 1'b1; bus.rq1_we = 1'b1; bus.rq1_addr = 32'h700; bus.rq1_wdata = 32'h2;
    #1;
    chk("rst ready0 first", {31'd0, bus.rq0_ready}, 32'd1);
    chk("rst ready1 first", {31'd0, bus.rq1_ready}, 32'd0);
    cyc();
    bus.rq0_valid = 1'b0;
    #1;
    chk("rst wr_addr", bus.ic0_axi_mst_wr_addr, 32'h600);
    chk("rst ready1 next", {31'd0, bus.rq1_ready}, 32'd1);
    cyc();
    bus.rq1_valid = 1'b0;
    #1;
    chk("rst wr_addr2", bus.ic0_axi_mst_wr_addr, 32'h700);
    chk("rst rsp1", {31'd0, bus.rq1_rsp_valid}, 32'd1);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
